// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and count-width helper shared by the FIFO files.
package fifo_pkg;
  localparam bit FWFT_STD  = 1'b0;
  localparam bit FWFT_FALL = 1'b1;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_v2_mem.sv
// fifo_v2_mem: storage with one synchronous write port and one asynchronous read port.
module fifo_v2_mem #(
  parameter int DW    = 128,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_v2.sv
// fifo_v2: synchronous FIFO with status flags, sticky error flags and standard or FWFT read mode.
module fifo_v2 import fifo_pkg::*; #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 16,
  parameter int ALMOST_MTY  = 1,
  parameter int ALMOST_FULL = 1,
  parameter int FWFT        = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      almost_full,
  output logic                      empty,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rd_data, w_head;
  logic                  r_rd_valid, r_ovf, r_udf, w_rd_acc, w_wr_acc;
  fifo_v2_mem #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .i_we(w_wr_acc & ~flush & ~rst), .i_waddr(r_wptr),
    .i_wdata(wr_data), .i_raddr(r_rptr), .o_rdata(w_head)
  );
  assign full         = r_count == CW'(DEPTH);
  assign empty        = r_count == '0;
  assign almost_full  = r_count >= CW'(DEPTH - ALMOST_FULL);
  assign almost_empty = r_count <= CW'(ALMOST_MTY);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  // a read frees the slot, so a full FIFO can still take a concurrent write
  assign w_rd_acc = rd_en & ~empty;
  assign w_wr_acc = wr_en & (~full | w_rd_acc);
  assign rd_data  = (FWFT == int'(FWFT_FALL)) ? w_head : r_rd_data;
  assign rd_valid = (FWFT == int'(FWFT_FALL)) ? ~empty : r_rd_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      r_ovf <= (wr_en & ~w_wr_acc & ~flush) | (r_ovf & ~err_clr);
      r_udf <= (rd_en & ~w_rd_acc & ~flush) | (r_udf & ~err_clr);
      if (flush) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_wptr     <= r_wptr + AW'(w_wr_acc);
        r_rptr     <= r_rptr + AW'(w_rd_acc);
        r_count    <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= w_head;
      end
    end
  end
endmodule

// File: tb/tb_fifo_v2.sv
// tb_fifo_v2: queue-model checker driving a standard and an FWFT instance with the same stimulus.
module tb_fifo_v2;
  localparam int DW = 128;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, flush = 0, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] d0_rd_data, d1_rd_data;
  logic d0_rd_valid, d0_full, d0_afull, d0_empty, d0_aempty, d0_ovf, d0_udf;
  logic d1_rd_valid, d1_full, d1_afull, d1_empty, d1_aempty, d1_ovf, d1_udf;
  logic [4:0] d0_count, d1_count;
  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd = '0;
  bit m_rv = 0, m_ov = 0, m_un = 0;

  always #5 clk = ~clk;

  fifo_v2 #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(d0_rd_data), .rd_valid(d0_rd_valid), .full(d0_full), .almost_full(d0_afull),
    .empty(d0_empty), .almost_empty(d0_aempty), .count(d0_count), .overflow(d0_ovf),
    .underflow(d0_udf), .err_clr(err_clr));
  fifo_v2 #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(d1_rd_data), .rd_valid(d1_rd_valid), .full(d1_full), .almost_full(d1_afull),
    .empty(d1_empty), .almost_empty(d1_aempty), .count(d1_count), .overflow(d1_ovf),
    .underflow(d1_udf), .err_clr(err_clr));

  task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ra, wa;
    ra = rd_en && q.size() > 0;
    wa = wr_en && (q.size() < DEPTH || ra);
    if (rst) begin
      q.delete(); m_rv = 0; m_rd = '0; m_ov = 0; m_un = 0;
    end else begin
      m_ov = (wr_en && !wa && !flush) || (m_ov && !err_clr);
      m_un = (rd_en && !ra && !flush) || (m_un && !err_clr);
      if (flush) begin
        q.delete(); m_rv = 0;
      end else begin
        m_rv = ra;
        if (ra) m_rd = q.pop_front();
        if (wa) q.push_back(wr_data);
      end
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    cmp("count", DW'(d0_count), DW'(n));
    cmp("count_fwft", DW'(d1_count), DW'(n));
    cmp("full", DW'(d0_full), DW'(n == DEPTH));
    cmp("empty", DW'(d0_empty), DW'(n == 0));
    cmp("almost_full", DW'(d0_afull), DW'(n >= DEPTH - 1));
    cmp("almost_empty", DW'(d0_aempty), DW'(n <= 1));
    cmp("flags_fwft", DW'({d1_full, d1_empty, d1_afull, d1_aempty}),
        DW'({n == DEPTH, n == 0, n >= DEPTH - 1, n <= 1}));
    cmp("overflow", DW'({d0_ovf, d1_ovf}), DW'({m_ov, m_ov}));
    cmp("underflow", DW'({d0_udf, d1_udf}), DW'({m_un, m_un}));
    cmp("rd_valid", DW'(d0_rd_valid), DW'(m_rv));
    cmp("rd_data", d0_rd_data, m_rd);
    cmp("rd_valid_fwft", DW'(d1_rd_valid), DW'(n > 0));
    if (n > 0) cmp("rd_data_fwft", d1_rd_data, q[0]);
  endtask

  task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                      input bit f = 0, input bit e = 0, input bit rs = 0);
    wr_en = w; rd_en = r; wr_data = d; flush = f; err_clr = e; rst = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    repeat (3) step(0, 0, '0, 0, 0, 1);
    cmp("rst_noX", DW'($isunknown({d0_rd_data, d0_rd_valid, d0_full, d0_afull, d0_empty,
        d0_aempty, d0_count, d0_ovf, d0_udf})), '0);
    cmp("rst_vals", DW'({d0_count, d0_empty, d0_aempty, d0_full, d0_afull, d0_rd_valid,
        d0_ovf, d0_udf}), DW'(10'b00000_11_00_0_00));
    cmp("rst_rd_data", d0_rd_data, '0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, DW'(i));
      if (i == DEPTH - 2) cmp("lit_afull15", DW'({d0_afull, d0_full}), DW'(2'b10));
    end
    cmp("lit_full16", DW'(d0_full), 1);
    step(1, 0, DW'(99));
    cmp("lit_ovf", DW'({d0_ovf, d0_count}), DW'({1'b1, 5'd16}));
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, '0);
      cmp("lit_rd_seq", d0_rd_data, DW'(i));
      if (i == DEPTH - 2) cmp("lit_aempty1", DW'({d0_aempty, d0_empty}), DW'(2'b10));
    end
    cmp("lit_empty", DW'(d0_empty), 1);
    step(0, 1, '0);
    cmp("lit_udf", DW'(d0_udf), 1);
    step(0, 0, '0, 0, 1);
    cmp("lit_errclr", DW'({d0_ovf, d0_udf}), '0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(32 + i));
    step(1, 1, DW'(200));
    cmp("lit_full_wr_rd", DW'({d0_count, d0_ovf}), DW'({5'd16, 1'b0}));
    cmp("lit_full_wr_rd_data", d0_rd_data, DW'(32));
    step(0, 0, '0, 1);
    cmp("lit_flush", DW'(d0_count), '0);
    step(1, 1, DW'('hA5));
    cmp("lit_mty_wr_rd", DW'({d0_count, d0_udf}), DW'({5'd1, 1'b1}));
    cmp("lit_fwft_a5", DW'({d1_rd_valid, d1_rd_data[7:0]}), DW'({1'b1, 8'hA5}));
    step(0, 1, '0);
    cmp("lit_fwft_pop", DW'({d1_empty, d1_rd_valid}), DW'(2'b10));
    cmp("lit_std_a5", d0_rd_data, DW'('hA5));
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(300 + i));
    step(1, 0, DW'(999), 0, 1);
    cmp("lit_errclr_vs_set", DW'(d0_ovf), 1);
    for (int i = 0; i < 11; i++) step(0, 1, '0);
    cmp("lit_wrap_data", d0_rd_data, DW'(310));
    cmp("lit_cnt5", DW'(d0_count), DW'(5));
    step(0, 0, '0, 1);
    cmp("lit_flush5", DW'({d0_count, d0_ovf}), DW'({5'd0, 1'b1}));
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 255) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_v2.md
FIFO_V2 -- requirements
Module: fifo_v2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, width of the data word.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, >= 4.
REQ-003 SHALL have parameter ALMOST_MTY, default 1, almost-empty threshold in entries.
REQ-004 SHALL have parameter ALMOST_FULL, default 1, almost-full threshold in free entries.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = standard, 1 = first-word-fall-through.
REQ-006 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 flush  in  1  synchronous content discard.
REQ-009 wr_en  in  1  write request; wr_data  in  DATA_WIDTH  write word.
REQ-010 rd_en  in  1  read request (pop).
REQ-011 rd_data  out  DATA_WIDTH  read word; rd_valid  out  1  rd_data is valid.
REQ-012 full, almost_full, empty, almost_empty  out  1 each  status flags.
REQ-013 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 overflow, underflow  out  1 each  sticky error flags; err_clr  in  1  clears both.

Function
REQ-015 Write SHALL be accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle).
REQ-016 Read SHALL be accepted when rd_en=1 and empty=0.
REQ-017 Rejected write SHALL leave the contents unchanged and set overflow; rejected read SHALL set underflow.
REQ-018 count SHALL be +1 on write only, -1 on read only, unchanged on both or neither; it never exceeds DEPTH.
REQ-019 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-020 Flags SHALL be combinational decodes of the count register: full = count==DEPTH; empty = count==0; almost_full = count>=DEPTH-ALMOST_FULL; almost_empty = count<=ALMOST_MTY.
REQ-021 FWFT=0: an accepted read SHALL register the head word into rd_data with rd_valid=1 on the next cycle; rd_valid=0 otherwise; rd_data holds its last value.
REQ-022 FWFT=1: rd_data SHALL equal the head word combinationally and rd_valid SHALL equal !empty; an accepted read advances to the next word on the next cycle.
REQ-023 A write to an empty FIFO SHALL be visible at the head on the following cycle (FWFT=1: rd_valid=1 one cycle after the write).
REQ-024 A write and a read on an empty FIFO in the same cycle: the write SHALL be accepted and the read rejected (underflow set).
REQ-025 flush SHALL zero pointers and count and clear rd_valid, overriding wr_en/rd_en in that cycle; overflow/underflow are not changed.
REQ-026 err_clr SHALL clear overflow/underflow; a set event in the same cycle takes precedence.

Reset
REQ-027 rst SHALL take priority over flush, err_clr, wr_en and rd_en.
REQ-028 After rst: count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0 (FWFT=0), overflow=0, underflow=0, pointers=0.
REQ-029 Storage array contents SHALL NOT be reset; no output may expose X after reset with FWFT=0.
REQ-030 rst asserted mid-transfer SHALL discard all stored words; the first word written after rst is the first word read.

Structure
REQ-031 fifo_pkg SHALL hold the FWFT mode constants and a function for the count width.
REQ-032 Storage SHALL be a sub-module fifo_v2_mem: one synchronous write port, one asynchronous read port, no reset.
REQ-033 Pointer, count, flag and error logic SHALL reside in fifo_v2.

Verification (DATA_WIDTH=128, DEPTH=16, thresholds 1)
REQ-034 rst for 3 cycles -> all outputs at reset values, no X on any output.
REQ-035 16 writes 0..15, then 1 extra write -> full=1 after 16th, almost_full=1 after 15th, extra rejected, overflow=1, count=16.
REQ-036 From full, 16 reads (FWFT=0) -> rd_data 0..15 each one cycle after its rd_en, empty=1, almost_empty=1 at count<=1; 17th read -> underflow=1.
REQ-037 FWFT=1, write 0xA5 to empty -> next cycle rd_valid=1, rd_data=0xA5 with no rd_en; rd_en -> empty next cycle.
REQ-038 At count=16, simultaneous wr/rd -> both accepted, count stays 16, no overflow; at count=0 simultaneous -> count=1, underflow=1.
REQ-039 20 writes/reads across wrap, flush at count=5, err_clr with concurrent rejected write -> count=0 after flush, overflow stays 1, data order preserved across wrap.
